// File: rtl/regfile_pkg.sv
// Shared definitions for the bypassing register file: clear-sequencer states
// and default geometry.
package regfile_pkg;

  localparam int DEF_DATA_W   = 13;
  localparam int DEF_NUM_REGS = 5;
  localparam int DEF_ADDR_W   = 3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SWEEP = 2'b01,
    ST_DONE  = 2'b10
  } clr_state_e;

endpackage

// File: rtl/regfile_bypass_if.sv
// Operand-bus bundle between the datapath control FSM (master) and the
// register file (slave).
interface regfile_bypass_if
  import regfile_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
) ();

  logic [ADDR_W-1:0] rp;
  logic [ADDR_W-1:0] rq;
  logic [ADDR_W-1:0] wa;
  logic [DATA_W-1:0] ld_data;
  logic              wr;
  logic              clr_req;
  logic [DATA_W-1:0] data_p;
  logic [DATA_W-1:0] data_q;
  logic              valid_p;
  logic              valid_q;
  logic              wr_stall;
  logic              clr_busy;
  logic              clr_done;

  modport master (
    output rp, rq, wa, ld_data, wr, clr_req,
    input  data_p, data_q, valid_p, valid_q, wr_stall, clr_busy, clr_done
  );

  modport slave (
    input  rp, rq, wa, ld_data, wr, clr_req,
    output data_p, data_q, valid_p, valid_q, wr_stall, clr_busy, clr_done
  );

endinterface

// File: rtl/regfile_row.sv
// One register-file entry: a data word plus a "written since last clear" bit.
module regfile_row
  import regfile_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [DATA_W-1:0] load_data,
  input  logic              sync_clr,
  output logic [DATA_W-1:0] data,
  output logic              valid
);

  logic [DATA_W-1:0] data_q, data_d;
  logic              valid_q, valid_d;

  // Load and sync-clear are mutually exclusive in practice; clear wins anyway.
  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    if (sync_clr) begin
      data_d  = '0;
      valid_d = 1'b0;
    end else if (load) begin
      data_d  = load_data;
      valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  assign data  = data_q;
  assign valid = valid_q;

endmodule

// File: rtl/regfile_bypass.sv
// Two-read / one-write register file with write-through bypass, valid bits,
// optional registered reads and a sequenced clear sweep.
module regfile_bypass
  import regfile_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int NUM_REGS = DEF_NUM_REGS,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int REG_READ = 0
) (
  input logic             clk,
  input logic             rst_n,
  regfile_bypass_if.slave bus
);

  localparam logic [ADDR_W:0]   NUM_REGS_A = (ADDR_W+1)'(NUM_REGS);
  localparam logic [ADDR_W-1:0] LAST_IDX   = ADDR_W'(NUM_REGS - 1);

  clr_state_e        state_q, state_d;
  logic [ADDR_W-1:0] idx_q, idx_d;

  logic              idle;
  logic              sweeping;
  logic              write_ok;

  logic [DATA_W-1:0] row_data  [NUM_REGS];
  logic              row_valid [NUM_REGS];

  logic [DATA_W-1:0] rd_data_p_d, rd_data_q_d;
  logic              rd_valid_p_d, rd_valid_q_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    case (state_q)
      ST_IDLE: begin
        idx_d = '0;
        if (bus.clr_req) state_d = ST_SWEEP;
      end
      ST_SWEEP: begin
        idx_d = idx_q + 1'b1;
        if (idx_q == LAST_IDX) state_d = ST_DONE;
      end
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Writes are refused for the whole non-idle window (sweep and done), so the
  // stall covers both states to tell the issuer its write was lost.
  always_comb begin
    idle         = (state_q == ST_IDLE);
    sweeping     = (state_q == ST_SWEEP);
    bus.clr_busy = sweeping;
    bus.clr_done = (state_q == ST_DONE);
    bus.wr_stall = !idle;
  end

  assign write_ok = bus.wr && idle && ({1'b0, bus.wa} < NUM_REGS_A);

  for (genvar i = 0; i < NUM_REGS; i++) begin : g_row
    localparam logic [ADDR_W-1:0] ROW_ADDR = ADDR_W'(i);

    regfile_row #(.DATA_W(DATA_W)) u_row (
      .clk       (clk),
      .rst_n     (rst_n),
      .load      (write_ok && (bus.wa == ROW_ADDR)),
      .load_data (bus.ld_data),
      .sync_clr  (sweeping && (idx_q == ROW_ADDR)),
      .data      (row_data[i]),
      .valid     (row_valid[i])
    );
  end

  // Unimplemented addresses fall through the loop and read as zero / invalid.
  always_comb begin
    rd_data_p_d  = '0;
    rd_valid_p_d = 1'b0;
    rd_data_q_d  = '0;
    rd_valid_q_d = 1'b0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (bus.rp == ADDR_W'(i)) begin
        rd_data_p_d  = row_data[i];
        rd_valid_p_d = row_valid[i];
      end
      if (bus.rq == ADDR_W'(i)) begin
        rd_data_q_d  = row_data[i];
        rd_valid_q_d = row_valid[i];
      end
    end
    if (write_ok && (bus.rp == bus.wa)) begin
      rd_data_p_d  = bus.ld_data;
      rd_valid_p_d = 1'b1;
    end
    if (write_ok && (bus.rq == bus.wa)) begin
      rd_data_q_d  = bus.ld_data;
      rd_valid_q_d = 1'b1;
    end
  end

  if (REG_READ != 0) begin : g_reg_read
    logic [DATA_W-1:0] rd_data_p_q, rd_data_q_q;
    logic              rd_valid_p_q, rd_valid_q_q;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        rd_data_p_q  <= '0;
        rd_data_q_q  <= '0;
        rd_valid_p_q <= 1'b0;
        rd_valid_q_q <= 1'b0;
      end else begin
        rd_data_p_q  <= rd_data_p_d;
        rd_data_q_q  <= rd_data_q_d;
        rd_valid_p_q <= rd_valid_p_d;
        rd_valid_q_q <= rd_valid_q_d;
      end
    end

    assign bus.data_p  = rd_data_p_q;
    assign bus.data_q  = rd_data_q_q;
    assign bus.valid_p = rd_valid_p_q;
    assign bus.valid_q = rd_valid_q_q;
  end else begin : g_comb_read
    assign bus.data_p  = rd_data_p_d;
    assign bus.data_q  = rd_data_q_d;
    assign bus.valid_p = rd_valid_p_d;
    assign bus.valid_q = rd_valid_q_d;
  end

endmodule
